serial_shift_unit: RTL and testbench



---
 rtl/serial_shift_unit.sv | 103 ++++++++++
 tb/tb_serial_shift_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_shift_unit.sv
// Iterative 32-bit shifter/rotator: one bit position per clock, valid/ready on both sides.
// Operands are captured on accept; Result is the working register, held stable in DONE.
module serial_shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       OpCode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] Result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [1:0]       op_q, op_d;
  logic [SW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] step;
  logic             unused_b_hi;

  // Only the low log2(WIDTH) bits of B select the shift amount.
  assign unused_b_hi = ^B[WIDTH-1:SW];

  always_comb begin
    step = work_q;
    unique case (op_q)
      2'b00: step = {work_q[WIDTH-2:0], 1'b0};
      2'b01: step = {1'b0, work_q[WIDTH-1:1]};
      2'b10: step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      2'b11: step = {work_q[0], work_q[WIDTH-1:1]};
      default: step = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    count_d = count_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_d  = A;
            op_d    = OpCode;
            count_d = B[SW-1:0];
            state_d = (B[SW-1:0] == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          work_d  = step;
          count_d = count_q - SW'(1);
          if (count_q == SW'(1)) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // out_valid is registered from the next state so it rises on the DONE-entry edge.
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      op_q        <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      op_q        <= op_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Result    = work_q;
  assign out_valid = out_valid_q;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit: hand-computed results, latency, handshake and abort checks.
module tb_serial_shift_unit;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [1:0]  OpCode;
  logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [31:0] Result;

  int total  = 0;
  int passed = 0;

  serial_shift_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .OpCode(OpCode),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .Result(Result), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one op, measure accept-to-out_valid latency, check Result, then drain.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    A = a; B = b; OpCode = op; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    A = $urandom; B = $urandom; OpCode = 2'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, Result, exp_res);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " drained"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [31:0] held;
    logic [2:0]  exp_bir [7];
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'd3; OpCode = SLL;

    // Reset with in_valid asserted: nothing may start.
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("reset result", Result, 32'h0);
    chk("reset ov/busy/in_ready", {29'd0, out_valid, busy, in_ready}, 32'b001);

    run_op("sll4",  32'h8000_0001, 32'd4,       SLL, 32'h0000_0010, 5);
    run_op("srl4",  32'h8000_0001, 32'd4,       SRL, 32'h0800_0000, 5);
    run_op("sra8",  32'hF000_00F0, 32'd8,       SRA, 32'hFFF0_0000, 9);
    run_op("ror8",  32'hF000_00F0, 32'd8,       ROR, 32'hF0F0_0000, 9);
    run_op("b_hi",  32'h1234_5678, 32'h0000_0120, SRA, 32'h1234_5678, 1);
    run_op("sra31", 32'h8000_0000, 32'd31,      SRA, 32'hFFFF_FFFF, 32);
    run_op("b0",    32'hA5A5_0F0F, 32'd0,       ROR, 32'hA5A5_0F0F, 1);
    run_op("ror1",  32'h0000_0001, 32'd1,       ROR, 32'h8000_0000, 2);
    run_op("sll31", 32'h0000_0003, 32'd31,      SLL, 32'h8000_0000, 32);

    // in_valid and out_ready held high: re-accept only after handshake plus one IDLE cycle.
    exp_bir = '{3'b100, 3'b100, 3'b110, 3'b001, 3'b100, 3'b100, 3'b110};
    A = 32'h1; B = 32'd2; OpCode = SLL; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 6) in_valid = 1'b0;
      chk($sformatf("b2b edge%0d busy/ov/in_ready", i), {29'd0, busy, out_valid, in_ready},
          {29'd0, exp_bir[i]});
    end
    chk("b2b result", Result, 32'h4);
    tick();
    out_ready = 1'b0;
    chk("b2b idle", {31'd0, in_ready}, 32'd1);

    // Backpressure: Result held while inputs toggle.
    A = 32'h0000_FFFF; B = 32'd4; OpCode = SLL; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("bp out_valid", {31'd0, out_valid}, 32'd1);
    held = 32'h000F_FFF0;
    for (int i = 0; i < 10; i++) begin
      A = $urandom; B = $urandom; OpCode = 2'($urandom);
      tick();
      chk($sformatf("bp hold%0d", i), Result, held);
      chk($sformatf("bp ov%0d", i), {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release", {30'd0, out_valid, in_ready}, 32'b01);

    // Flush mid-SHIFT with a simultaneous request.
    A = 32'h1; B = 32'd10; OpCode = SLL; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    flush = 1'b1; in_valid = 1'b1;
    tick();
    chk("flush shift", {29'd0, out_valid, busy, in_ready}, 32'b001);
    tick();
    chk("flush blocks accept", {29'd0, out_valid, busy, in_ready}, 32'b001);
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("flush no late ov", {30'd0, out_valid, busy}, 32'b00);

    // Flush while holding a result in DONE.
    A = 32'h5; B = 32'd0; OpCode = SRL; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre-flush done", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush done", {29'd0, out_valid, busy, in_ready}, 32'b001);
    tick();
    chk("flush done stays", {31'd0, out_valid}, 32'd0);

    // Reset mid-SHIFT, then a normal op.
    A = 32'hFFFF_FFFF; B = 32'd20; OpCode = SRA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst mid result", Result, 32'h0);
    chk("rst mid flags", {29'd0, out_valid, busy, in_ready}, 32'b001);
    run_op("post-rst srl3", 32'h8000_0000, 32'd3, SRL, 32'h1000_0000, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
